// File: rtl/e203_irq_stim_ctrl_pkg.sv
// Purpose: shared types, default PCs and LFSR step for the IRQ stimulus scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package e203_irq_stim_ctrl_pkg;

  // Per-channel scheduler state; encoding is visible on the debug side of the harness
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_ASSERT = 2'd2,
    ST_HALT   = 2'd3
  } chan_state_t;

  // Default PCs from the E203 self-check image
  localparam logic [31:0] DEF_START_PC   = 32'h8000015C;
  localparam logic [31:0] DEF_TOHOST_PC  = 32'h80000086;
  localparam logic [31:0] DEF_EXT_ACK_PC = 32'h800000A6;
  localparam logic [31:0] DEF_SFT_ACK_PC = 32'h800000BE;
  localparam logic [31:0] DEF_TMR_ACK_PC = 32'h800000D6;

  localparam logic [31:0] DEF_LFSR_SEED  = 32'hACE12468;
  localparam logic [31:0] LFSR_TAPS      = 32'h80200003;

  // Right-shifting Galois step: the bit shifted out folds the tap mask back in
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    lfsr_step = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/e203_irq_stim_ctrl_if.sv
// Purpose: commit-stage bus in, forced interrupt lines out, between core harness and scheduler.
// Latency: n/a (wires only).
// Backpressure: none; commit is a pure valid strobe, interrupts are level signals.
interface e203_irq_stim_ctrl_if #(
  parameter int PC_SIZE = 32
);

  logic               cmt_valid;
  logic [PC_SIZE-1:0] cmt_pc;
  logic               ext_irq;
  logic               sft_irq;
  logic               tmr_irq;

  // Core / harness side: drives commits, receives interrupts
  modport master (
    output cmt_valid,
    output cmt_pc,
    input  ext_irq,
    input  sft_irq,
    input  tmr_irq
  );

  // Scheduler side: observes commits, drives interrupts
  modport slave (
    input  cmt_valid,
    input  cmt_pc,
    output ext_irq,
    output sft_irq,
    output tmr_irq
  );

endinterface

// File: rtl/e203_irq_stim_chan.sv
// Purpose: one interrupt channel: wait a loaded gap, assert, hold until ACK, then regap or halt.
// Latency: entering GAP with gap G raises irq G cycles later; ACK drops irq the next cycle.
// Backpressure: none; irq is held until the handler ACK PC commits.
module e203_irq_stim_chan
  import e203_irq_stim_ctrl_pkg::*;
#(
  parameter int GAP_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ack,
  input  logic             start,
  input  logic             enable,
  input  logic             stop,
  input  logic [GAP_W-1:0] gap_seed,
  output logic             irq,
  output logic             halted
);

  localparam logic [GAP_W:0] CNT_ONE = {{GAP_W{1'b0}}, 1'b1};

  chan_state_t      state;
  logic [GAP_W:0]   gap_cnt;
  logic [GAP_W:0]   gap_load;

  // Gap is seed+1 so a zero seed still waits one cycle and the max is 2^GAP_W
  assign gap_load = {1'b0, gap_seed} + CNT_ONE;

  // Channel FSM with registered irq/halted; disable parks any live channel in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      irq     <= 1'b0;
      halted  <= 1'b0;
    end else if (!enable && (state != ST_HALT)) begin
      state <= ST_IDLE;
      irq   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_GAP;
            gap_cnt <= gap_load;
          end
        end
        ST_GAP: begin
          // Leaving on count 1 makes the irq visible exactly G cycles after GAP entry
          if (gap_cnt == CNT_ONE) begin
            state <= ST_ASSERT;
            irq   <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - CNT_ONE;
          end
        end
        ST_ASSERT: begin
          // Stop is only honoured here, so a pending gap always finishes its assertion
          if (ack) begin
            irq <= 1'b0;
            if (stop) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= gap_load;
            end
          end
        end
        ST_HALT: begin
          irq <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/e203_irq_stim_ctrl.sv
// Purpose: PC-driven scheduler forcing ext/sft/tmr interrupts with pseudo-random gaps.
// Latency: START commit arms channels next cycle; all outputs registered, no input-to-output path.
// Backpressure: none; each irq is held until its handler ACK PC commits.
module e203_irq_stim_ctrl
  import e203_irq_stim_ctrl_pkg::*;
#(
  parameter int                 PC_SIZE    = 32,
  parameter logic [PC_SIZE-1:0] START_PC   = DEF_START_PC,
  parameter logic [PC_SIZE-1:0] TOHOST_PC  = DEF_TOHOST_PC,
  parameter logic [PC_SIZE-1:0] EXT_ACK_PC = DEF_EXT_ACK_PC,
  parameter logic [PC_SIZE-1:0] SFT_ACK_PC = DEF_SFT_ACK_PC,
  parameter logic [PC_SIZE-1:0] TMR_ACK_PC = DEF_TMR_ACK_PC,
  parameter logic [31:0]        STOP_CNT   = 32'd32,
  parameter int                 GAP_W      = 10,
  parameter logic [31:0]        LFSR_SEED  = DEF_LFSR_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  e203_irq_stim_ctrl_if.slave  bus,
  output logic                 started,
  output logic                 done,
  output logic [31:0]          tohost_cnt
);

  logic [31:0] lfsr;
  logic        hit_start;
  logic        hit_tohost;
  logic        hit_ext_ack;
  logic        hit_sft_ack;
  logic        hit_tmr_ack;
  logic        stop;
  logic        chan_start;
  logic        ext_irq_r, sft_irq_r, tmr_irq_r;
  logic        ext_halted, sft_halted, tmr_halted;

  // Commit-PC decode
  assign hit_start   = bus.cmt_valid && (bus.cmt_pc == START_PC);
  assign hit_tohost  = bus.cmt_valid && (bus.cmt_pc == TOHOST_PC);
  assign hit_ext_ack = bus.cmt_valid && (bus.cmt_pc == EXT_ACK_PC);
  assign hit_sft_ack = bus.cmt_valid && (bus.cmt_pc == SFT_ACK_PC);
  assign hit_tmr_ack = bus.cmt_valid && (bus.cmt_pc == TMR_ACK_PC);

  // Stop decision uses the registered count, so an ACK right after a tohost write sees it
  assign stop = (tohost_cnt > STOP_CNT);

  // Look-ahead of started so channels enter GAP in the cycle after the START commit
  assign chan_start = started || (hit_start && enable);

  // Free-running LFSR, independent of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // Saturating tohost commit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost_cnt <= 32'd0;
    end else if (hit_tohost && (tohost_cnt != 32'hFFFF_FFFF)) begin
      tohost_cnt <= tohost_cnt + 32'd1;
    end
  end

  // Sticky armed flag: once START commits while enabled it holds until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
    end else if (hit_start && enable) begin
      started <= 1'b1;
    end
  end

  e203_irq_stim_chan #(.GAP_W(GAP_W)) u_ext (
    .clk      (clk),
    .rst_n    (rst_n),
    .ack      (hit_ext_ack),
    .start    (chan_start),
    .enable   (enable),
    .stop     (stop),
    .gap_seed (lfsr[GAP_W-1:0]),
    .irq      (ext_irq_r),
    .halted   (ext_halted)
  );

  e203_irq_stim_chan #(.GAP_W(GAP_W)) u_sft (
    .clk      (clk),
    .rst_n    (rst_n),
    .ack      (hit_sft_ack),
    .start    (chan_start),
    .enable   (enable),
    .stop     (stop),
    .gap_seed (lfsr[2*GAP_W-1:GAP_W]),
    .irq      (sft_irq_r),
    .halted   (sft_halted)
  );

  e203_irq_stim_chan #(.GAP_W(GAP_W)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .ack      (hit_tmr_ack),
    .start    (chan_start),
    .enable   (enable),
    .stop     (stop),
    .gap_seed (lfsr[3*GAP_W-1:2*GAP_W]),
    .irq      (tmr_irq_r),
    .halted   (tmr_halted)
  );

  assign bus.ext_irq = ext_irq_r;
  assign bus.sft_irq = sft_irq_r;
  assign bus.tmr_irq = tmr_irq_r;

  // All halted flags are flops, so done carries no input-to-output path
  assign done = ext_halted && sft_halted && tmr_halted;

endmodule

// File: tb/tb_e203_irq_stim_ctrl.sv
// Purpose: randomized check of the IRQ scheduler against a due-time reference model.
// Latency: compares every cycle on the falling edge, one cycle after stimulus.
// Backpressure: n/a; ACKs are steered toward channels the model believes are asserted.
module tb_e203_irq_stim_ctrl;

  localparam logic [31:0] START_PC   = 32'h8000015C;
  localparam logic [31:0] TOHOST_PC  = 32'h80000086;
  localparam logic [31:0] EXT_ACK_PC = 32'h800000A6;
  localparam logic [31:0] SFT_ACK_PC = 32'h800000BE;
  localparam logic [31:0] TMR_ACK_PC = 32'h800000D6;
  localparam logic [31:0] SEED       = 32'hACE12468;

  localparam int K_IDLE = 0, K_RAND = 1, K_DRAIN = 2, K_START = 3,
                 K_TOHOST = 4, K_HOLD = 5, K_NOEN = 6;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        started0, started1, done0, done1;
  logic [31:0] cnt0, cnt1;

  e203_irq_stim_ctrl_if bus0();
  e203_irq_stim_ctrl_if bus1();

  // Instance 0: default PCs. Instance 1: all three ACK PCs equal, so one commit ACKs every channel.
  e203_irq_stim_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus0),
    .started(started0), .done(done0), .tohost_cnt(cnt0)
  );

  e203_irq_stim_ctrl #(
    .SFT_ACK_PC(EXT_ACK_PC), .TMR_ACK_PC(EXT_ACK_PC)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus1),
    .started(started1), .done(done1), .tohost_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: each channel is idle, counting down to an absolute due cycle, on, or halted
  logic [31:0] ack_pc [2][3];
  logic [31:0] m_lfsr;
  logic [31:0] m_cnt;
  bit          m_started;
  bit          m_on    [2][3];
  bit          m_armed [2][3];
  bit          m_halt  [2][3];
  int unsigned m_due   [2][3];
  int unsigned cyc;

  bit          s_en, s_v;
  logic [31:0] s_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_lfsr    = SEED;
    m_cnt     = 32'd0;
    m_started = 1'b0;
    cyc       = 0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 3; c++) begin
        m_on[i][c]    = 1'b0;
        m_armed[i][c] = 1'b0;
        m_halt[i][c]  = 1'b0;
        m_due[i][c]   = 0;
      end
  endtask

  task automatic model_step(input bit en, input bit v, input logic [31:0] pc);
    bit          stop_now;
    bit          go;
    int unsigned g;
    stop_now = (m_cnt > 32);
    go       = m_started || (v && (pc == START_PC) && en);
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 3; c++) begin
        g = ((m_lfsr >> (10 * c)) & 32'h3FF) + 1;
        if (m_halt[i][c]) begin
          // terminal
        end else if (!en) begin
          m_on[i][c]    = 1'b0;
          m_armed[i][c] = 1'b0;
        end else if (m_on[i][c]) begin
          if (v && (pc == ack_pc[i][c])) begin
            m_on[i][c] = 1'b0;
            if (stop_now) m_halt[i][c] = 1'b1;
            else begin
              m_armed[i][c] = 1'b1;
              m_due[i][c]   = cyc + 1 + g;
            end
          end
        end else if (m_armed[i][c]) begin
          if (m_due[i][c] == cyc + 1) begin
            m_on[i][c]    = 1'b1;
            m_armed[i][c] = 1'b0;
          end
        end else if (go) begin
          m_armed[i][c] = 1'b1;
          m_due[i][c]   = cyc + 1 + g;
        end
      end
    if (v && (pc == TOHOST_PC) && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 1;
    if (v && (pc == START_PC) && en) m_started = 1'b1;
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
    cyc++;
  endtask

  task automatic check_outputs();
    chk("ext0", bus0.ext_irq, m_on[0][0]);
    chk("sft0", bus0.sft_irq, m_on[0][1]);
    chk("tmr0", bus0.tmr_irq, m_on[0][2]);
    chk("ext1", bus1.ext_irq, m_on[1][0]);
    chk("sft1", bus1.sft_irq, m_on[1][1]);
    chk("tmr1", bus1.tmr_irq, m_on[1][2]);
    chk("done0", done0, m_halt[0][0] && m_halt[0][1] && m_halt[0][2]);
    chk("done1", done1, m_halt[1][0] && m_halt[1][1] && m_halt[1][2]);
    chk("started0", started0, m_started);
    chk("started1", started1, m_started);
    chk("cnt0", cnt0, m_cnt);
    chk("cnt1", cnt1, m_cnt);
  endtask

  // Pick an ACK PC for some channel the model currently has asserted
  task automatic pick_ack(output bit found, output logic [31:0] pc);
    logic [31:0] q[$];
    for (int c = 0; c < 3; c++)
      if (m_on[0][c]) q.push_back(ack_pc[0][c]);
    if (m_on[1][0] || m_on[1][1] || m_on[1][2]) q.push_back(EXT_ACK_PC);
    found = (q.size() > 0);
    pc    = found ? q[$urandom_range(0, q.size() - 1)] : 32'h0;
  endtask

  task automatic apply();
    enable         = s_en;
    bus0.cmt_valid = s_v;
    bus1.cmt_valid = s_v;
    bus0.cmt_pc    = s_pc;
    bus1.cmt_pc    = s_pc;
  endtask

  // Called at a falling edge: check, drive, step model at the rising edge, return at next falling edge
  task automatic cycle(input int kind);
    bit          found;
    logic [31:0] p;
    int          r;
    check_outputs();
    s_en = 1'b1;
    s_v  = 1'($urandom_range(0, 1));
    s_pc = $urandom;
    pick_ack(found, p);
    case (kind)
      K_IDLE:   s_v = 1'b0;
      K_START:  begin s_v = 1'b1; s_pc = START_PC;  end
      K_TOHOST: begin s_v = 1'b1; s_pc = TOHOST_PC; end
      K_HOLD:   s_v = 1'b0;
      K_NOEN:   begin s_v = 1'b0; s_en = 1'b0; end
      K_DRAIN: begin
        if (found && ($urandom_range(0, 3) == 0)) begin s_v = 1'b1; s_pc = p; end
      end
      default: begin
        s_en = ($urandom_range(0, 399) != 0);
        r    = $urandom_range(0, 1999);
        if (r == 0) begin s_v = 1'b1; s_pc = TOHOST_PC; end
        else if (r < 40) begin s_v = 1'b1; s_pc = ack_pc[0][$urandom_range(0, 2)]; end
        else if (r < 50) begin s_v = 1'b1; s_pc = START_PC; end
        else if (found && ($urandom_range(0, 5) == 0)) begin s_v = 1'b1; s_pc = p; end
      end
    endcase
    apply();
    @(posedge clk);
    if (rst_n) model_step(s_en, s_v, s_pc);
    @(negedge clk);
  endtask

  initial begin
    ack_pc[0][0] = EXT_ACK_PC; ack_pc[0][1] = SFT_ACK_PC; ack_pc[0][2] = TMR_ACK_PC;
    ack_pc[1][0] = EXT_ACK_PC; ack_pc[1][1] = EXT_ACK_PC; ack_pc[1][2] = EXT_ACK_PC;
    rst_n = 1'b0;
    s_en = 1'b1; s_v = 1'b0; s_pc = 32'h0;
    apply();
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Enabled but never armed: nothing may assert
    repeat (2000) cycle(K_IDLE);

    // Arm and run randomized traffic with enable drops and steered ACKs
    repeat (10) cycle(K_IDLE);
    cycle(K_START);
    repeat (20000) cycle(K_RAND);

    // Timer asserted, drop enable one cycle, then it must regap without a new START
    for (int n = 0; n < 3000 && !m_on[0][2]; n++) cycle(K_HOLD);
    chk("tmr_wait", bus0.tmr_irq, 1);
    cycle(K_NOEN);
    chk("tmr_drop", bus0.tmr_irq, 0);
    for (int n = 0; n < 3000 && !m_on[0][2]; n++) cycle(K_HOLD);
    chk("tmr_regap", bus0.tmr_irq, 1);

    // Push tohost past the threshold, then drain every channel into HALT
    for (int n = 0; n < 40 && m_cnt <= 32; n++) cycle(K_TOHOST);
    chk("stop_cnt", cnt0, 33);
    for (int n = 0; n < 15000 && !(m_halt[0][0] && m_halt[0][1] && m_halt[0][2] &&
                                   m_halt[1][0] && m_halt[1][1] && m_halt[1][2]); n++)
      cycle(K_DRAIN);
    chk("done0_final", done0, 1);
    chk("done1_final", done1, 1);
    repeat (2000) cycle(K_DRAIN);

    // Fresh run, then reset while the software IRQ is high
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle(K_IDLE);
    cycle(K_START);
    repeat (3) cycle(K_TOHOST);
    for (int n = 0; n < 3000 && !m_on[0][1]; n++) cycle(K_HOLD);
    chk("sft_wait", bus0.sft_irq, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sft", bus0.sft_irq, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_started", started0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2000) cycle(K_DRAIN);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
